// File: rtl/stage_seq.sv
// Single-clock stage sequencer: issues one-hot stage-enable strobes with per-stage
// wait states, memory stall, flush, single-step halt and a retired-instruction count.
module stage_seq #(
    parameter  int NUM_STAGES = 5,
    parameter  int WAIT_W     = 4,
    localparam int SW         = $clog2(NUM_STAGES)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_run,
    input  logic                         i_step_mode,
    input  logic                         i_step,
    input  logic [NUM_STAGES*WAIT_W-1:0] i_stage_wait,
    input  logic                         i_mem_busy,
    input  logic                         i_flush,
    output logic [NUM_STAGES-1:0]        o_stage_en,
    output logic [SW-1:0]                o_stage,
    output logic                         o_instr_done,
    output logic [31:0]                  o_retired,
    output logic                         o_idle,
    output logic                         o_halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [SW-1:0]       r_stage;
    logic [SW-1:0]       w_nextStage;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [WAIT_W-1:0]   w_nextWaitCnt;
    logic [31:0]         r_retired;
    logic [31:0]         w_nextRetired;
    logic                w_commit;
    logic                w_lastStage;

    function automatic logic [WAIT_W-1:0] waitOf(input logic [NUM_STAGES*WAIT_W-1:0] waits,
                                                 input logic [SW-1:0] idx);
        return waits[int'(idx)*WAIT_W +: WAIT_W];
    endfunction

    // Reset gates the strobe too, so a reset cycle never commits a stage.
    assign w_commit    = (r_state == S_RUN) && !i_reset && !i_flush && !i_mem_busy
                         && (r_waitCnt == '0);
    assign w_lastStage = (r_stage == LAST_STAGE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_stage   <= '0;
            r_waitCnt <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_nextState;
            r_stage   <= w_nextStage;
            r_waitCnt <= w_nextWaitCnt;
            r_retired <= w_nextRetired;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextStage   = r_stage;
        w_nextWaitCnt = r_waitCnt;
        w_nextRetired = r_retired;
        unique case (r_state)
            S_IDLE: begin
                if (i_run || (i_step_mode && i_step)) begin
                    w_nextState   = S_RUN;
                    w_nextStage   = '0;
                    w_nextWaitCnt = waitOf(i_stage_wait, '0);
                end
            end
            S_RUN: begin
                // Priority: flush, then stall, then wait-state countdown, then commit.
                if (i_flush) begin
                    w_nextStage   = '0;
                    w_nextWaitCnt = waitOf(i_stage_wait, '0);
                end else if (i_mem_busy) begin
                    w_nextWaitCnt = r_waitCnt;
                end else if (r_waitCnt != '0) begin
                    w_nextWaitCnt = r_waitCnt - WAIT_W'(1);
                end else if (!w_lastStage) begin
                    w_nextStage   = r_stage + SW'(1);
                    w_nextWaitCnt = waitOf(i_stage_wait, r_stage + SW'(1));
                end else begin
                    w_nextRetired = r_retired + 32'd1;
                    w_nextStage   = '0;
                    if (i_step_mode) begin
                        w_nextState   = S_HALT;
                        w_nextWaitCnt = '0;
                    end else if (!i_run) begin
                        w_nextState   = S_IDLE;
                        w_nextWaitCnt = '0;
                    end else begin
                        w_nextWaitCnt = waitOf(i_stage_wait, '0);
                    end
                end
            end
            S_HALT: begin
                if (i_step || (!i_step_mode && i_run)) begin
                    w_nextState   = S_RUN;
                    w_nextStage   = '0;
                    w_nextWaitCnt = waitOf(i_stage_wait, '0);
                end else if (!i_step_mode) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState   = S_IDLE;
                w_nextStage   = '0;
                w_nextWaitCnt = '0;
            end
        endcase
    end

    always_comb begin
        o_stage_en   = '0;
        o_instr_done = 1'b0;
        if (w_commit) begin
            o_stage_en   = NUM_STAGES'(1) << r_stage;
            o_instr_done = w_lastStage;
        end
    end

    assign o_stage   = r_stage;
    assign o_retired = r_retired;
    assign o_idle    = (r_state == S_IDLE);
    assign o_halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_stage_seq.sv
// Directed bench for stage_seq: per-cycle strobe expectations go through a scoreboard
// queue, registered outputs are checked at the instruction boundaries of each scenario.
module tb_stage_seq;

    localparam int NS = 5;
    localparam int WW = 4;

    logic             clk;
    logic             reset;
    logic             run;
    logic             stepMode;
    logic             step;
    logic [NS*WW-1:0] stageWait;
    logic             memBusy;
    logic             flush;
    logic [NS-1:0]    stageEn;
    logic [2:0]       stage;
    logic             instrDone;
    logic [31:0]      retired;
    logic             idle;
    logic             halted;

    typedef struct {
        logic [NS-1:0] en;
        logic          done;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    stage_seq #(.NUM_STAGES(NS), .WAIT_W(WW)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_run        (run),
        .i_step_mode  (stepMode),
        .i_step       (step),
        .i_stage_wait (stageWait),
        .i_mem_busy   (memBusy),
        .i_flush      (flush),
        .o_stage_en   (stageEn),
        .o_stage      (stage),
        .o_instr_done (instrDone),
        .o_retired    (retired),
        .o_idle       (idle),
        .o_halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic runV, input logic stepModeV, input logic stepV,
                                 input logic busyV, input logic flushV);
        run      = runV;
        stepMode = stepModeV;
        step     = stepV;
        memBusy  = busyV;
        flush    = flushV;
    endtask

    task automatic pushExp(input logic [NS-1:0] en, input logic done);
        exp_t e;
        e.en   = en;
        e.done = done;
        expQ.push_back(e);
    endtask

    // One stall-free instruction: wait[s] empty cycles, then the stage-s strobe.
    task automatic pushInstr(input logic [NS*WW-1:0] waits);
        for (int s = 0; s < NS; s++) begin
            repeat (int'(waits[s*WW +: WW])) pushExp('0, 1'b0);
            pushExp(NS'(1) << s, s == NS - 1);
        end
    endtask

    task automatic doCycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            #1;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
            end else begin
                e = expQ.pop_front();
                checkOutput("stage_en", 32'(stageEn), 32'(e.en));
                checkOutput("instr_done", 32'(instrDone), 32'(e.done));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        stageWait = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_stage_en", 32'(stageEn), 32'd0);
        checkOutput("rst_instr_done", 32'(instrDone), 32'd0);
        checkOutput("rst_stage", 32'(stage), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_idle", 32'(idle), 32'd1);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] free run");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        pushInstr('0);
        pushInstr('0);
        doCycles(11);
        checkOutput("free_retired2", retired, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushInstr('0);
        pushExp('0, 1'b0);
        doCycles(6);
        checkOutput("free_idle", 32'(idle), 32'd1);
        checkOutput("free_retired3", retired, 32'd3);

        $display("[TB] wait states");
        stageWait = 20'h00300;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        pushInstr(20'h00300);
        doCycles(9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushInstr(20'h00300);
        pushExp('0, 1'b0);
        doCycles(3);
        checkOutput("wait_stage2", 32'(stage), 32'd2);
        stageWait = '0;
        doCycles(6);
        checkOutput("wait_retired", retired, 32'd5);

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        for (int s = 0; s < 3; s++) pushExp(NS'(1) << s, 1'b0);
        doCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pushExp('0, 1'b0);
            checkOutput("stall_stage", 32'(stage), 32'd3);
            doCycles(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp(5'b01000, 1'b0);
        pushExp(5'b10000, 1'b1);
        pushExp('0, 1'b0);
        doCycles(3);
        checkOutput("stall_retired", retired, 32'd6);

        $display("[TB] flush");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        for (int s = 0; s < 4; s++) pushExp(NS'(1) << s, 1'b0);
        doCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        pushExp('0, 1'b0);
        doCycles(1);
        checkOutput("flush_stage0", 32'(stage), 32'd0);
        checkOutput("flush_retired", retired, 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushInstr('0);
        pushExp('0, 1'b0);
        doCycles(6);
        checkOutput("flush_retired_after", retired, 32'd7);

        $display("[TB] reset mid-instruction");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        pushExp(5'b00001, 1'b0);
        pushExp(5'b00010, 1'b0);
        doCycles(3);
        checkOutput("pre_rst_stage", 32'(stage), 32'd2);
        checkOutput("pre_rst_retired", retired, 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_stage_en", 32'(stageEn), 32'd0);
        checkOutput("mid_rst_instr_done", 32'(instrDone), 32'd0);
        checkOutput("mid_rst_stage", 32'(stage), 32'd0);
        checkOutput("mid_rst_retired", retired, 32'd0);
        checkOutput("mid_rst_idle", 32'(idle), 32'd1);
        checkOutput("mid_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);

        $display("[TB] single step");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        doCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(5'b00001, 1'b0);
        doCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pushExp(5'b00010, 1'b0);
        doCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(5'b00100, 1'b0);
        pushExp(5'b01000, 1'b0);
        pushExp(5'b10000, 1'b1);
        pushExp('0, 1'b0);
        doCycles(4);
        checkOutput("step_halted", 32'(halted), 32'd1);
        checkOutput("step_retired1", retired, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pushExp('0, 1'b0);
        doCycles(1);
        checkOutput("halt_flush_ignored", 32'(halted), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        doCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushInstr('0);
        pushExp('0, 1'b0);
        doCycles(6);
        checkOutput("step2_halted", 32'(halted), 32'd1);
        checkOutput("step_retired2", retired, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        doCycles(1);
        checkOutput("halt_to_idle", 32'(idle), 32'd1);
        checkOutput("halt_cleared", 32'(halted), 32'd0);

        $display("[TB] retired wrap");
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        checkOutput("wrap_preload", retired, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExp('0, 1'b0);
        doCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushInstr('0);
        pushExp('0, 1'b0);
        doCycles(6);
        checkOutput("wrap_retired", retired, 32'd0);
        checkOutput("wrap_idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
